// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: drives a 1-cycle synchronous instruction memory,
// pairs each returned word with its PC and hands it downstream over valid/ready.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        iCLK,
    input  logic        iRST,
    output logic [31:0] oFetchAddr,
    input  logic [31:0] iMemInst,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPC,
    output logic        oValid,
    input  logic        iReady,
    output logic [31:0] oInst,
    output logic [31:0] oPC,
    output logic        oFault
);

    localparam logic [32:0] FETCH_LIMIT = 33'(MEM_WORDS) * 33'd4;

    logic [31:0] rPC;
    logic        rReqV;
    logic [31:0] rReqPC;
    logic        rSkidV;
    logic [31:0] rSkidInst;
    logic [31:0] rSkidPC;
    logic        rFault;

    logic        wInRange;
    logic        wSlotFree;
    logic        wIssue;
    logic        wSkidCapture;
    logic        wSkidDrain;
    logic [31:0] wRedirectTarget;

    // A new fetch may go out only when whatever is presented this cycle is
    // leaving (iReady) or nothing is held at all, so one word is in flight at most.
    assign wInRange        = {1'b0, rPC} < FETCH_LIMIT;
    assign wSlotFree       = iReady | (~rSkidV & ~rReqV);
    assign wIssue          = wSlotFree & wInRange & ~rFault;
    assign wSkidCapture    = rReqV & ~rSkidV & ~iReady;
    assign wSkidDrain      = rSkidV & iReady;
    assign wRedirectTarget = iRedirectPC & ~32'h0000_0003;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rPC    <= RESET_PC;
            rReqV  <= 1'b0;
            rReqPC <= '0;
        end else if (iRedirect) begin
            rPC   <= wRedirectTarget;
            rReqV <= 1'b0;
        end else if (wIssue) begin
            rReqV  <= 1'b1;
            rReqPC <= rPC;
            rPC    <= rPC + 32'd4;
        end else begin
            rReqV <= 1'b0;
        end
    end

    // The returning word is parked here when downstream stalls; the memory
    // output is not held, so this is the only copy until it is accepted.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rSkidV    <= 1'b0;
            rSkidInst <= '0;
            rSkidPC   <= '0;
        end else if (iRedirect) begin
            rSkidV <= 1'b0;
        end else if (wSkidCapture) begin
            rSkidV    <= 1'b1;
            rSkidInst <= iMemInst;
            rSkidPC   <= rReqPC;
        end else if (wSkidDrain) begin
            rSkidV <= 1'b0;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rFault <= 1'b0;
        end else if (iRedirect) begin
            rFault <= 1'b0;
        end else if (~wInRange & ~rFault & wSlotFree) begin
            rFault <= 1'b1;
        end
    end

    assign oFetchAddr = rPC;
    assign oValid     = (rSkidV | rReqV) & ~iRedirect;
    assign oInst      = rSkidV ? rSkidInst : iMemInst;
    assign oPC        = rSkidV ? rSkidPC : rReqPC;
    assign oFault     = rFault;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a full-size instance and a 4-word instance,
// each fed by its own registered memory model holding mem[i] = A000_0000 + i.
module tb_inst_fetch_unit;

    typedef struct {
        logic        ready;
        logic        redirect;
        logic [31:0] redirPc;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expInst;
        logic        expFault;
    } vecT;

    logic        clock;
    logic        reset;

    logic [31:0] fetchAddrA, memInstA, redirPcA, instA, pcA;
    logic        redirA, readyA, validA, faultA;
    logic [31:0] fetchAddrB, memInstB, redirPcB, instB, pcB;
    logic        redirB, readyB, validB, faultB;

    int total;
    int bad;

    vecT vecA [24];
    vecT vecB [10];
    vecT vecR [5];

    inst_fetch_unit dutA (
        .iCLK        (clock),
        .iRST        (reset),
        .oFetchAddr  (fetchAddrA),
        .iMemInst    (memInstA),
        .iRedirect   (redirA),
        .iRedirectPC (redirPcA),
        .oValid      (validA),
        .iReady      (readyA),
        .oInst       (instA),
        .oPC         (pcA),
        .oFault      (faultA)
    );

    inst_fetch_unit #(.MEM_WORDS(4)) dutB (
        .iCLK        (clock),
        .iRST        (reset),
        .oFetchAddr  (fetchAddrB),
        .iMemInst    (memInstB),
        .iRedirect   (redirB),
        .iRedirectPC (redirPcB),
        .oValid      (validB),
        .iReady      (readyB),
        .oInst       (instB),
        .oPC         (pcB),
        .oFault      (faultB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Registered-read instruction memories.
    always_ff @(posedge clock) begin
        memInstA <= 32'hA000_0000 + (fetchAddrA >> 2);
        memInstB <= 32'hA000_0000 + (fetchAddrB >> 2);
    end

    function automatic vecT mkVec(input logic rdy, input logic redir, input logic [31:0] rpc,
                                  input logic ev, input logic [31:0] epc,
                                  input logic [31:0] einst, input logic ef);
        vecT v;
        v.ready    = rdy;
        v.redirect = redir;
        v.redirPc  = rpc;
        v.expValid = ev;
        v.expPc    = epc;
        v.expInst  = einst;
        v.expFault = ef;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit sel, input vecT v, input string tag);
        @(negedge clock);
        if (sel) begin
            readyB   = v.ready;
            redirB   = v.redirect;
            redirPcB = v.redirPc;
        end else begin
            readyA   = v.ready;
            redirA   = v.redirect;
            redirPcA = v.redirPc;
        end
        #1;
        checkOutput({tag, " valid"}, {31'd0, sel ? validB : validA}, {31'd0, v.expValid});
        checkOutput({tag, " fault"}, {31'd0, sel ? faultB : faultA}, {31'd0, v.expFault});
        if (v.expValid) begin
            checkOutput({tag, " pc"},   sel ? pcB : pcA,     v.expPc);
            checkOutput({tag, " inst"}, sel ? instB : instA, v.expInst);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        readyA = 1'b1; redirA = 1'b0; redirPcA = '0;
        readyB = 1'b0; redirB = 1'b0; redirPcB = '0;

        // Streaming, stall with skid, redirect and redirect-over-full-skid on the big instance.
        vecA[0]  = mkVec(1, 0, 0,     1, 32'h00, 32'hA000_0000, 0);
        vecA[1]  = mkVec(1, 0, 0,     1, 32'h04, 32'hA000_0001, 0);
        vecA[2]  = mkVec(1, 0, 0,     1, 32'h08, 32'hA000_0002, 0);
        vecA[3]  = mkVec(1, 0, 0,     1, 32'h0C, 32'hA000_0003, 0);
        vecA[4]  = mkVec(1, 1, 32'h8, 0, 0,      0,             0);
        vecA[5]  = mkVec(1, 0, 0,     0, 0,      0,             0);
        vecA[6]  = mkVec(0, 0, 0,     1, 32'h08, 32'hA000_0002, 0);
        vecA[7]  = mkVec(0, 0, 0,     1, 32'h08, 32'hA000_0002, 0);
        vecA[8]  = mkVec(0, 0, 0,     1, 32'h08, 32'hA000_0002, 0);
        vecA[9]  = mkVec(1, 0, 0,     1, 32'h08, 32'hA000_0002, 0);
        vecA[10] = mkVec(1, 0, 0,     1, 32'h0C, 32'hA000_0003, 0);
        vecA[11] = mkVec(1, 0, 0,     1, 32'h10, 32'hA000_0004, 0);
        vecA[12] = mkVec(1, 1, 32'h4, 0, 0,      0,             0);
        vecA[13] = mkVec(1, 0, 0,     0, 0,      0,             0);
        vecA[14] = mkVec(1, 1, 32'h42, 0, 0,     0,             0);
        vecA[15] = mkVec(1, 0, 0,     0, 0,      0,             0);
        vecA[16] = mkVec(1, 0, 0,     1, 32'h40, 32'hA000_0010, 0);
        vecA[17] = mkVec(1, 0, 0,     1, 32'h44, 32'hA000_0011, 0);
        vecA[18] = mkVec(0, 0, 0,     1, 32'h48, 32'hA000_0012, 0);
        vecA[19] = mkVec(0, 0, 0,     1, 32'h48, 32'hA000_0012, 0);
        vecA[20] = mkVec(0, 1, 32'h20, 0, 0,     0,             0);
        vecA[21] = mkVec(0, 0, 0,     0, 0,      0,             0);
        vecA[22] = mkVec(1, 0, 0,     1, 32'h20, 32'hA000_0008, 0);
        vecA[23] = mkVec(1, 0, 0,     1, 32'h24, 32'hA000_0009, 0);

        // Restart at 0 and stream up to oPC=8, where reset is then asserted.
        vecR[0] = mkVec(1, 1, 32'h0, 0, 0,      0,             0);
        vecR[1] = mkVec(1, 0, 0,     0, 0,      0,             0);
        vecR[2] = mkVec(1, 0, 0,     1, 32'h00, 32'hA000_0000, 0);
        vecR[3] = mkVec(1, 0, 0,     1, 32'h04, 32'hA000_0001, 0);
        vecR[4] = mkVec(1, 0, 0,     1, 32'h08, 32'hA000_0002, 0);

        // Four-word instance: run off the end, fault, then recover by redirect.
        vecB[0] = mkVec(1, 0, 0,     1, 32'h00, 32'hA000_0000, 0);
        vecB[1] = mkVec(1, 0, 0,     1, 32'h04, 32'hA000_0001, 0);
        vecB[2] = mkVec(1, 0, 0,     1, 32'h08, 32'hA000_0002, 0);
        vecB[3] = mkVec(1, 0, 0,     1, 32'h0C, 32'hA000_0003, 0);
        vecB[4] = mkVec(1, 0, 0,     0, 0,      0,             1);
        vecB[5] = mkVec(1, 0, 0,     0, 0,      0,             1);
        vecB[6] = mkVec(1, 1, 32'h0, 0, 0,      0,             1);
        vecB[7] = mkVec(1, 0, 0,     0, 0,      0,             0);
        vecB[8] = mkVec(1, 0, 0,     1, 32'h00, 32'hA000_0000, 0);
        vecB[9] = mkVec(1, 0, 0,     1, 32'h04, 32'hA000_0001, 0);

        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("reset validA",  {31'd0, validA}, 32'd0);
        checkOutput("reset faultA",  {31'd0, faultA}, 32'd0);
        checkOutput("reset addrA",   fetchAddrA,      32'h0);
        checkOutput("reset validB",  {31'd0, validB}, 32'd0);
        checkOutput("reset faultB",  {31'd0, faultB}, 32'd0);

        for (int i = 0; i < 24; i++) applyStimulus(1'b0, vecA[i], $sformatf("A%0d", i));
        for (int i = 0; i < 5; i++)  applyStimulus(1'b0, vecR[i], $sformatf("R%0d", i));

        // Async reset while oPC=8 is presented must clear outputs without a clock edge.
        reset = 1'b1;
        #1;
        checkOutput("midreset validA", {31'd0, validA}, 32'd0);
        checkOutput("midreset faultA", {31'd0, faultA}, 32'd0);
        checkOutput("midreset addrA",  fetchAddrA,      32'h0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("release validA", {31'd0, validA}, 32'd0);
        applyStimulus(1'b0, mkVec(1, 0, 0, 1, 32'h00, 32'hA000_0000, 0), "refetch0");
        applyStimulus(1'b0, mkVec(1, 0, 0, 1, 32'h04, 32'hA000_0001, 0), "refetch1");

        @(negedge clock);
        readyA = 1'b0;
        reset  = 1'b1;
        @(negedge clock);
        reset  = 1'b0;
        readyB = 1'b1;
        #1;
        checkOutput("resetB validB", {31'd0, validB}, 32'd0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, vecB[i], $sformatf("B%0d", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
